// File: rtl/preg_file_multiport_if.sv
// Register-file port bundle: read addresses/data, write ports, clear control and status.
// The master drives addresses and writes; the register file is the slave.
interface preg_file_multiport_if #(
  parameter int unsigned NUM_REGS    = 64,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned READ_PORTS  = 4,
  parameter int unsigned WRITE_PORTS = 2
);
  localparam int unsigned AW = $clog2(NUM_REGS);

  logic                              rstStart;
  logic [READ_PORTS*AW-1:0]          rdAddr;
  logic [READ_PORTS*DATA_WIDTH-1:0]  rdData;
  logic [WRITE_PORTS-1:0]            wrEn;
  logic [WRITE_PORTS*AW-1:0]         wrAddr;
  logic [WRITE_PORTS*DATA_WIDTH-1:0] wrData;
  logic                              ready;
  logic                              initBusy;

  modport master (
    output rstStart, rdAddr, wrEn, wrAddr, wrData,
    input  rdData, ready, initBusy
  );

  modport slave (
    input  rstStart, rdAddr, wrEn, wrAddr, wrData,
    output rdData, ready, initBusy
  );
endinterface

// File: rtl/preg_file_multiport.sv
// Generic physical register file: N synchronous read ports with write bypass,
// M write ports (highest port wins), and a one-register-per-cycle clear sequencer.
module preg_file_multiport #(
  parameter int unsigned NUM_REGS    = 64,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned READ_PORTS  = 4,
  parameter int unsigned WRITE_PORTS = 2,
  parameter int unsigned ZERO_REG    = 1
) (
  input logic                  clk,
  input logic                  rst,
  preg_file_multiport_if.slave bus
);
  localparam int unsigned AW     = $clog2(NUM_REGS);
  localparam bit          ZeroEn = (ZERO_REG != 0);

  typedef enum logic [1:0] {IDLE, INIT, READY} state_t;

  state_t                state;
  logic [AW-1:0]         clrCnt;
  logic                  readyQ;
  logic                  initBusyQ;
  logic [DATA_WIDTH-1:0] regs   [NUM_REGS];
  logic [DATA_WIDTH-1:0] rdNext [READ_PORTS];
  logic [DATA_WIDTH-1:0] rdQ    [READ_PORTS];

  // Clear sequencer; status flags are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      clrCnt    <= '0;
      readyQ    <= 1'b0;
      initBusyQ <= 1'b0;
    end else begin
      case (state)
        IDLE, READY: begin
          if (bus.rstStart) begin
            state     <= INIT;
            clrCnt    <= '0;
            initBusyQ <= 1'b1;
            readyQ    <= 1'b0;
          end
        end
        INIT: begin
          if (bus.rstStart) begin
            clrCnt <= '0;
          end else if (clrCnt == AW'(NUM_REGS - 1)) begin
            state     <= READY;
            clrCnt    <= '0;
            initBusyQ <= 1'b0;
            readyQ    <= 1'b1;
          end else begin
            clrCnt <= clrCnt + AW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          clrCnt    <= '0;
          initBusyQ <= 1'b0;
          readyQ    <= 1'b0;
        end
      endcase
    end
  end

  // Storage is deliberately not reset; the clear sequence initialises it.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      regs[clrCnt] <= '0;
    end else if (state == READY) begin
      for (int w = 0; w < WRITE_PORTS; w++) begin
        if (bus.wrEn[w] && !(ZeroEn && bus.wrAddr[w*AW +: AW] == '0)) begin
          regs[bus.wrAddr[w*AW +: AW]] <= bus.wrData[w*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Read value with same-cycle bypass; later write ports override earlier ones.
  always_comb begin
    for (int r = 0; r < READ_PORTS; r++) begin
      rdNext[r] = regs[bus.rdAddr[r*AW +: AW]];
      for (int w = 0; w < WRITE_PORTS; w++) begin
        if (bus.wrEn[w] && bus.wrAddr[w*AW +: AW] == bus.rdAddr[r*AW +: AW]) begin
          rdNext[r] = bus.wrData[w*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      if (ZeroEn && bus.rdAddr[r*AW +: AW] == '0) begin
        rdNext[r] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < READ_PORTS; r++) rdQ[r] <= '0;
    end else begin
      for (int r = 0; r < READ_PORTS; r++) begin
        rdQ[r] <= (state == READY) ? rdNext[r] : '0;
      end
    end
  end

  for (genvar r = 0; r < READ_PORTS; r++) begin : gRdOut
    assign bus.rdData[r*DATA_WIDTH +: DATA_WIDTH] = rdQ[r];
  end

  assign bus.ready    = readyQ;
  assign bus.initBusy = initBusyQ;
endmodule

// File: tb/tb_preg_file_multiport.sv
// Bench for preg_file_multiport: directed scenarios plus random traffic checked
// against an array-based reference model of the register file.
module tb_preg_file_multiport;
  localparam int unsigned NR = 64;
  localparam int unsigned DW = 32;
  localparam int unsigned RP = 4;
  localparam int unsigned WP = 2;
  localparam int unsigned AW = $clog2(NR);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  preg_file_multiport_if #(.NUM_REGS(NR), .DATA_WIDTH(DW), .READ_PORTS(RP), .WRITE_PORTS(WP)) bus ();

  preg_file_multiport #(.NUM_REGS(NR), .DATA_WIDTH(DW), .READ_PORTS(RP),
                        .WRITE_PORTS(WP), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic          rs;
  logic [AW-1:0] ra [RP];
  logic          we [WP];
  logic [AW-1:0] wa [WP];
  logic [DW-1:0] wd [WP];

  assign bus.rstStart = rs;
  for (genvar i = 0; i < RP; i++) begin : gRa
    assign bus.rdAddr[i*AW +: AW] = ra[i];
  end
  for (genvar i = 0; i < WP; i++) begin : gWr
    assign bus.wrEn[i]            = we[i];
    assign bus.wrAddr[i*AW +: AW] = wa[i];
    assign bus.wrData[i*DW +: DW] = wd[i];
  end

  // Reference model: contents, ready flag, and remaining clear cycles.
  logic [DW-1:0] model [NR];
  bit            mR;
  int            mL;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idleIns();
    rs = 1'b0;
    for (int i = 0; i < RP; i++) ra[i] = '0;
    for (int i = 0; i < WP; i++) begin we[i] = 1'b0; wa[i] = '0; wd[i] = '0; end
  endtask

  function automatic logic [DW-1:0] rdPort(input int p);
    return bus.rdData[p*DW +: DW];
  endfunction

  // One clock: predict, advance to the following falling edge, compare everything.
  task automatic cycle(input string tag);
    logic [DW-1:0] exp [RP];
    for (int r = 0; r < RP; r++) begin
      exp[r] = '0;
      if (mR && ra[r] != 0) begin
        exp[r] = model[ra[r]];
        for (int w = 0; w < WP; w++) if (we[w] && wa[w] == ra[r]) exp[r] = wd[w];
      end
    end
    if (mR) for (int w = 0; w < WP; w++) if (we[w] && wa[w] != 0) model[wa[w]] = wd[w];
    if (rs) begin
      mL = NR; mR = 1'b0;
    end else if (mL > 0) begin
      mL--;
      if (mL == 0) begin
        mR = 1'b1;
        for (int i = 0; i < NR; i++) model[i] = '0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    for (int r = 0; r < RP; r++) chk($sformatf("%s.rd%0d", tag, r), rdPort(r), exp[r]);
    chk({tag, ".ready"}, DW'(bus.ready), DW'(mR));
    chk({tag, ".initBusy"}, DW'(bus.initBusy), DW'(mL > 0));
  endtask

  task automatic clearSeq(input string tag);
    rs = 1'b1;
    cycle({tag, ".start"});
    rs = 1'b0;
    for (int i = 0; i < NR; i++) cycle(tag);
  endtask

  task automatic checkResetOuts(input string tag);
    for (int r = 0; r < RP; r++) chk($sformatf("%s.rd%0d", tag, r), rdPort(r), '0);
    chk({tag, ".ready"}, DW'(bus.ready), '0);
    chk({tag, ".initBusy"}, DW'(bus.initBusy), '0);
  endtask

  initial begin
    idleIns();
    mR = 1'b0; mL = 0;
    for (int i = 0; i < NR; i++) model[i] = '0;

    #1 checkResetOuts("reset");
    @(negedge clk);
    rst = 1'b0;

    // IDLE: writes ignored, no status
    we[0] = 1'b1; wa[0] = AW'(4); wd[0] = 32'hCAFE0001; ra[0] = AW'(4);
    for (int i = 0; i < 3; i++) cycle("idle");
    idleIns();

    clearSeq("init");
    chk("init.readyConst", DW'(bus.ready), 32'd1);
    for (int b = 0; b < NR; b += RP) begin
      for (int r = 0; r < RP; r++) ra[r] = AW'(b + r);
      cycle("sweep");
      for (int r = 0; r < RP; r++) chk("sweepZero", rdPort(r), '0);
    end
    idleIns();

    // basic write then read on another port
    we[0] = 1'b1; wa[0] = AW'(5); wd[0] = 32'hDEADBEEF;
    cycle("basicWr");
    idleIns(); ra[3] = AW'(5);
    cycle("basicRd");
    chk("basicLit", rdPort(3), 32'hDEADBEEF);

    // same-cycle bypass, neighbour keeps old value
    idleIns();
    we[1] = 1'b1; wa[1] = AW'(9); wd[1] = 32'h12345678; ra[0] = AW'(9); ra[1] = AW'(10);
    cycle("bypass");
    chk("bypassLit", rdPort(0), 32'h12345678);
    chk("bypassOld", rdPort(1), '0);

    // collision: port 1 wins
    idleIns();
    we[0] = 1'b1; wa[0] = AW'(7); wd[0] = 32'hAAAA0000;
    we[1] = 1'b1; wa[1] = AW'(7); wd[1] = 32'h5555FFFF; ra[2] = AW'(7);
    cycle("collide");
    chk("collideByp", rdPort(2), 32'h5555FFFF);
    idleIns(); ra[2] = AW'(7);
    cycle("collideRd");
    chk("collideLit", rdPort(2), 32'h5555FFFF);

    // zero register
    idleIns();
    we[0] = 1'b1; wa[0] = '0; wd[0] = 32'hFFFFFFFF; ra[0] = '0;
    we[1] = 1'b1; wa[1] = '0; wd[1] = 32'hFFFFFFFF;
    cycle("zeroByp");
    chk("zeroBypLit", rdPort(0), '0);
    idleIns(); ra[1] = '0;
    cycle("zeroRd");
    chk("zeroRdLit", rdPort(1), '0);

    // restart with writes attempted during INIT
    idleIns();
    we[0] = 1'b1; wa[0] = AW'(3); wd[0] = 32'h77;
    cycle("fill3");
    idleIns(); ra[0] = AW'(3);
    cycle("fill3Rd");
    chk("fill3Lit", rdPort(0), 32'h77);
    idleIns();
    rs = 1'b1;
    cycle("restart");
    rs = 1'b0;
    for (int i = 0; i < NR; i++) begin
      we[0] = 1'b1; wa[0] = AW'(3); wd[0] = $urandom;
      we[1] = 1'b1; wa[1] = AW'($urandom_range(1, NR - 1)); wd[1] = $urandom;
      ra[0] = AW'(3);
      cycle("restartInit");
    end
    idleIns(); ra[0] = AW'(3);
    cycle("after3");
    chk("after3Lit", rdPort(0), '0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      rs = ($urandom_range(0, 299) == 0);
      for (int r = 0; r < RP; r++)
        ra[r] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NR - 1)) : AW'($urandom_range(0, 15));
      for (int w = 0; w < WP; w++) begin
        we[w] = $urandom_range(0, 1) == 1;
        wa[w] = AW'($urandom_range(0, 15));
        wd[w] = $urandom;
      end
      cycle("rand");
    end
    idleIns();

    // abort at INIT cycle 20
    rs = 1'b1;
    cycle("abortStart");
    rs = 1'b0;
    for (int i = 0; i < 20; i++) cycle("abortInit");
    rst = 1'b1;
    mR = 1'b0; mL = 0;
    #1 checkResetOuts("abortRst");
    @(negedge clk);
    rst = 1'b0;
    we[0] = 1'b1; wa[0] = AW'(6); wd[0] = 32'h600D; ra[0] = AW'(6);
    for (int i = 0; i < 10; i++) cycle("abortIdle");
    idleIns();

    clearSeq("reinit");
    for (int b = 0; b < NR; b += RP) begin
      for (int r = 0; r < RP; r++) ra[r] = AW'(b + r);
      cycle("reSweep");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
